// File: rtl/serial_parity_checker.sv
// Bit-serial frame receiver: captures DATA_W data bits LSB-first, checks one
// trailing parity bit, and presents the word plus an error flag for one cycle.
module serial_parity_checker #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              busy,
  output logic [DATA_W-1:0] frame_data,
  output logic              parity_err,
  output logic              frame_valid
);

  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_n;
  logic [CW-1:0]     count_q, count_n;
  logic              acc_q, acc_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic [DATA_W-1:0] data_n;
  logic              err_n;
  logic              busy_n;
  logic              fv_n;

  always_comb begin
    state_n = state_q;
    count_n = count_q;
    acc_n   = acc_q;
    shift_n = shift_q;
    data_n  = frame_data;
    err_n   = parity_err;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n = DATA;
          count_n = '0;
          acc_n   = 1'b0;
          shift_n = '0;
        end
      end
      DATA, PAR: begin
        // Restart wins over a bit presented in the same cycle.
        if (start) begin
          state_n = DATA;
          count_n = '0;
          acc_n   = 1'b0;
          shift_n = '0;
        end else if (bit_valid) begin
          if (state_q == DATA) begin
            // Register is cleared on entry, so OR-ing places the bit at count.
            shift_n = shift_q | (DATA_W'(bit_in) << count_q);
            acc_n   = acc_q ^ bit_in;
            if (count_q == LAST) begin
              state_n = PAR;
            end else begin
              count_n = count_q + 1'b1;
            end
          end else begin
            err_n   = acc_q ^ bit_in ^ ODD;
            data_n  = shift_q;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    busy_n = (state_n == DATA) || (state_n == PAR);
    fv_n   = (state_n == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      acc_q       <= 1'b0;
      shift_q     <= '0;
      frame_data  <= '0;
      parity_err  <= 1'b0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      state_q     <= state_n;
      count_q     <= count_n;
      acc_q       <= acc_n;
      shift_q     <= shift_n;
      frame_data  <= data_n;
      parity_err  <= err_n;
      busy        <= busy_n;
      frame_valid <= fv_n;
    end
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: an even-parity and an odd-parity
// instance share the same stimulus; expected values are hand-computed.
module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       bit_in;
  logic       bit_valid;
  logic       busy_e, busy_o;
  logic [7:0] data_e, data_o;
  logic       err_e, err_o;
  logic       fv_e, fv_o;

  int checks = 0;
  int errors = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(8), .PARITY_ODD(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .busy(busy_e), .frame_data(data_e),
    .parity_err(err_e), .frame_valid(fv_e)
  );

  serial_parity_checker #(.DATA_W(8), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .busy(busy_o), .frame_data(data_o),
    .parity_err(err_o), .frame_valid(fv_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic s, input logic v, input logic b);
    start = s; bit_valid = v; bit_in = b;
    @(posedge clk);
    #1;
  endtask

  // Full frame; rb drives bit_valid/bit_in alongside start on the start cycle.
  task automatic frame(input logic [7:0] d, input logic p, input bit gaps, input logic rb,
                       input logic exp_err_e, input logic exp_err_o);
    busy_cnt = 0;
    cyc(1'b1, rb, rb);
    if (busy_e) busy_cnt++;
    for (int unsigned i = 0; i < 8; i++) begin
      if (gaps) begin
        for (int unsigned g = 0; g < $urandom_range(3, 1); g++) begin
          cyc(1'b0, 1'b0, 1'b1);
          if (busy_e) busy_cnt++;
        end
      end
      cyc(1'b0, 1'b1, d[i]);
      if (busy_e) busy_cnt++;
      chk("no_early_valid", {31'd0, fv_e}, 32'd0);
    end
    cyc(1'b0, 1'b1, p);
    chk("fv_pulse", {31'd0, fv_e}, 32'd1);
    chk("busy_in_done", {31'd0, busy_e}, 32'd0);
    chk("data_even", {24'd0, data_e}, {24'd0, d});
    chk("err_even", {31'd0, err_e}, {31'd0, exp_err_e});
    chk("data_odd", {24'd0, data_o}, {24'd0, d});
    chk("err_odd", {31'd0, err_o}, {31'd0, exp_err_o});
    cyc(1'b1, 1'b0, 1'b0);  // start in DONE is ignored
    chk("fv_one_cycle", {31'd0, fv_e}, 32'd0);
    chk("idle_after_done", {31'd0, busy_e}, 32'd0);
    chk("data_hold", {24'd0, data_e}, {24'd0, d});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy_e}, 32'd0);
    chk("rst_fv", {31'd0, fv_e}, 32'd0);
    chk("rst_err", {31'd0, err_e}, 32'd0);
    chk("rst_data", {24'd0, data_e}, 32'd0);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    // IDLE ignores bit_valid
    cyc(1'b0, 1'b1, 1'b1);
    chk("idle_ignore_busy", {31'd0, busy_e}, 32'd0);

    // 0xA5 with correct even parity; busy spans 9 cycles
    frame(8'hA5, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("busy_cycles", busy_cnt, 32'd9);

    // 0xA5 with parity 1: even flags error, odd accepts
    frame(8'hA5, 1'b1, 0, 1'b0, 1'b1, 1'b0);

    // 0x3C with idle gaps between bits
    frame(8'h3C, 1'b0, 1, 1'b0, 1'b0, 1'b1);

    // Abort after 3 bits; no pulse, previous results held
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("abort_busy", {31'd0, busy_e}, 32'd1);
    // Restart cycle carries a valid '1' bit that must be discarded
    frame(8'h0F, 1'b0, 0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a frame, mid-cycle
    cyc(1'b1, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("pre_rst_busy", {31'd0, busy_e}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy_e}, 32'd0);
    chk("async_data", {24'd0, data_e}, 32'd0);
    chk("async_err_odd", {31'd0, err_o}, 32'd0);
    chk("async_fv", {31'd0, fv_e}, 32'd0);
    @(posedge clk); #4 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int unsigned i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      if (busy_e !== 1'b0 || fv_e !== 1'b0 || data_e !== 8'h00) begin
        chk("no_start_quiet", {22'd0, busy_e, fv_e, data_e}, 32'd0);
      end
    end
    chk("no_start_busy", {31'd0, busy_e}, 32'd0);
    chk("no_start_data", {24'd0, data_e}, 32'd0);
    frame(8'h81, 1'b0, 0, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
Bit-serial frame receiver that sits directly upstream of the 2-input XOR stage. It folds each incoming bit into a running parity accumulator and captures the bits into a parallel data word. After DATA_W data bits it takes one parity bit, compares it against the accumulated parity, and presents the captured word with an error flag for one cycle.

Parameters:
DATA_W, 8, number of data bits per frame (2..32)
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin (or restart) frame reception
bit_in  input  1  serial data/parity bit
bit_valid  input  1  bit_in is valid this cycle
busy  output  1  frame reception in progress (DATA or PAR state)
frame_data  output  DATA_W  captured data word, LSB received first
parity_err  output  1  parity mismatch on last completed frame
frame_valid  output  1  one-cycle pulse, frame_data/parity_err updated

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting rst_n low immediately forces state IDLE, and clears count, accumulator and shift register.
  - All outputs go to 0 (busy, frame_data, parity_err, frame_valid).
- State IDLE:
  - busy=0; bit_valid is ignored.
  - start=1 -> DATA; count=0, acc=0, shift register cleared.
- State DATA:
  - busy=1.
  - Each cycle with bit_valid=1: shift[count] <= bit_in, acc <= acc ^ bit_in, count <= count+1.
  - Cycles with bit_valid=0 change nothing.
  - On the accepted bit with count==DATA_W-1 -> PAR.
- State PAR:
  - busy=1.
  - On bit_valid=1:
    - parity_err <= acc ^ bit_in ^ PARITY_ODD.
    - frame_data <= shift register (including the final data bit).
    - Next state DONE.
- State DONE:
  - frame_valid=1 for exactly this one cycle; busy=0.
  - start is ignored; next state IDLE unconditionally.
- Latency: frame_valid is asserted in the cycle after the parity bit is accepted.
- start=1 in DATA or PAR aborts the current frame and restarts:
  - count, acc and shift register are cleared; state becomes DATA.
  - No frame_valid is produced for the aborted frame.
  - frame_data and parity_err keep their previous values.
- start and bit_valid high in the same cycle in DATA/PAR: restart has priority and the bit is discarded.
- frame_data and parity_err hold their values between frames; they change only on parity-bit acceptance or reset.
- count width: $clog2(DATA_W)+1 bits; it never exceeds DATA_W-1 while in DATA.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Assert rst_n=0 asynchronously mid-cycle -> busy=0, frame_valid=0, parity_err=0, frame_data=0x00 immediately, without waiting for a clock edge.
2. DATA_W=8, PARITY_ODD=0: start, then bits 1,0,1,0,0,1,0,1 (0xA5), parity 0 with bit_valid continuous -> one cycle after the parity bit, frame_valid=1 for one cycle, frame_data=0xA5, parity_err=0; busy=1 for 9 cycles.
3. Same frame with parity bit 1 -> frame_data=0xA5, parity_err=1. Repeat on a PARITY_ODD=1 instance with parity 1 -> parity_err=0.
4. Frame 0x3C, parity 0, with bit_valid deasserted for 1-3 random cycles between bits -> frame_data=0x3C, parity_err=0; only valid cycles are counted.
5. start, 3 bits, start again, then full frame 0x0F with parity 0 -> exactly one frame_valid pulse, frame_data=0x0F, parity_err=0. Drive start with bit_valid on the restart cycle and confirm that bit is discarded.
6. rst_n low after 5 data bits, released, then bits fed without start -> outputs stay 0 and busy=0. A following start plus frame 0x81, parity 0 -> frame_data=0x81, parity_err=0.
